// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the pipeline control and the program-counter unit.
// The master drives the control requests; the slave (pc_unit) returns the PC and its status.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            hd;
    logic            halt;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            trap;
    logic            call;
    logic            ret;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [1:0]      state;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output start, hd, halt, redirect, redirect_pc, trap, call, ret,
        input  pc, pc_valid, state, ras_empty, ras_full
    );

    modport slave (
        input  start, hd, halt, redirect, redirect_pc, trap, call, ret,
        output pc, pc_valid, state, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_unit.sv
// IF-stage program counter with an IDLE/RUN/HALT controller, flush/stall priority
// and a small circular return-address stack for call/return prediction.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] TRAP_PC   = 'h100,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    pc_unit_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [CW-1:0]   ras_cnt;
    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] pc_inc;
    logic            ras_empty;

    // ras_ptr names the next free slot, so the top entry sits one below it.
    assign top_idx   = ras_ptr - 1'b1;
    assign pc_inc    = pc + XLEN'(INC);
    assign ras_empty = (ras_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.start) begin
                        if (bus.trap) begin
                            pc <= TRAP_PC;
                        end else if (bus.redirect) begin
                            pc <= bus.redirect_pc;
                        end else if (!bus.hd) begin
                            if (bus.halt) begin
                                state <= HALT;
                            end else if (bus.ret && !ras_empty) begin
                                pc <= ras_mem[top_idx];
                                // A simultaneous call replaces the popped entry in place.
                                if (bus.call) begin
                                    ras_mem[top_idx] <= pc_inc;
                                end else begin
                                    ras_ptr <= top_idx;
                                    ras_cnt <= ras_cnt - 1'b1;
                                end
                            end else begin
                                pc <= pc_inc;
                                if (bus.call) begin
                                    // When full the write lands on the oldest entry.
                                    ras_mem[ras_ptr] <= pc_inc;
                                    ras_ptr          <= ras_ptr + 1'b1;
                                    if (ras_cnt != CW'(RAS_DEPTH)) begin
                                        ras_cnt <= ras_cnt + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                HALT: begin
                    if (bus.trap) begin
                        pc    <= TRAP_PC;
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc        = pc;
    assign bus.state     = state;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = (ras_cnt == CW'(RAS_DEPTH));
    assign bus.pc_valid  = (state == RUN) && bus.start && !bus.hd && !bus.halt &&
                           !bus.trap && !bus.redirect;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues hand-computed expectations,
// a monitor pops and compares them one clock after each driven cycle.
module tb_pc_unit;
    localparam logic [6:0] ST = 7'h40;
    localparam logic [6:0] HD = 7'h20;
    localparam logic [6:0] HL = 7'h10;
    localparam logic [6:0] RD = 7'h08;
    localparam logic [6:0] TR = 7'h04;
    localparam logic [6:0] CL = 7'h02;
    localparam logic [6:0] RT = 7'h01;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        e;
        logic        f;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input int step,
                               input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %h want %h", name, step, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] ctl, input logic [31:0] rpc,
                                 input logic [31:0] epc, input logic [1:0] est,
                                 input logic ee, input logic ef, input logic ev);
        exp_t x;
        @(negedge clk);
        {bus.start, bus.hd, bus.halt, bus.redirect, bus.trap, bus.call, bus.ret} = ctl;
        bus.redirect_pc = rpc;
        step_no++;
        x.step = step_no;
        x.pc   = epc;
        x.st   = est;
        x.e    = ee;
        x.f    = ef;
        x.v    = ev;
        sb.push_back(x);
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        checkOutput("drain", step_no, 32'(sb.size()), 32'd0);
    endtask

    task automatic zeroInputs();
        {bus.start, bus.hd, bus.halt, bus.redirect, bus.trap, bus.call, bus.ret} = 7'h00;
        bus.redirect_pc = '0;
    endtask

    // Monitor: compare the queued expectation one time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                checkOutput("pc",        x.step, bus.pc,               x.pc);
                checkOutput("state",     x.step, 32'(bus.state),       32'(x.st));
                checkOutput("ras_empty", x.step, 32'(bus.ras_empty),   32'(x.e));
                checkOutput("ras_full",  x.step, 32'(bus.ras_full),    32'(x.f));
                checkOutput("pc_valid",  x.step, 32'(bus.pc_valid),    32'(x.v));
            end
        end
    end

    initial begin
        zeroInputs();
        #12;
        checkOutput("rst_pc",    0, bus.pc,             32'h0);
        checkOutput("rst_state", 0, 32'(bus.state),     32'(S_IDLE));
        checkOutput("rst_empty", 0, 32'(bus.ras_empty), 32'd1);
        checkOutput("rst_full",  0, 32'(bus.ras_full),  32'd0);
        checkOutput("rst_valid", 0, 32'(bus.pc_valid),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start-up and sequential fetch
        applyStimulus(ST, 0, 32'h0,  S_RUN, 1, 0, 1);
        applyStimulus(ST, 0, 32'h4,  S_RUN, 1, 0, 1);
        applyStimulus(ST, 0, 32'h8,  S_RUN, 1, 0, 1);
        applyStimulus(ST, 0, 32'hC,  S_RUN, 1, 0, 1);
        applyStimulus(ST, 0, 32'h10, S_RUN, 1, 0, 1);

        // Stalls, and redirect winning over a stall
        applyStimulus(ST | RD, 32'h20, 32'h20, S_RUN, 1, 0, 0);
        applyStimulus(ST | HD, 0, 32'h20, S_RUN, 1, 0, 0);
        applyStimulus(ST | HD, 0, 32'h20, S_RUN, 1, 0, 0);
        applyStimulus(ST | HD, 0, 32'h20, S_RUN, 1, 0, 0);
        applyStimulus(ST,      0, 32'h24, S_RUN, 1, 0, 1);
        applyStimulus(ST | HD, 0, 32'h24, S_RUN, 1, 0, 0);
        applyStimulus(ST | HD | RD, 32'h80, 32'h80, S_RUN, 1, 0, 0);
        applyStimulus(ST,      0, 32'h84, S_RUN, 1, 0, 1);
        applyStimulus(7'h00,   0, 32'h84, S_RUN, 1, 0, 0);

        // Trap priority, halt and trap out of halt
        applyStimulus(ST | RD, 32'h40, 32'h40, S_RUN, 1, 0, 0);
        applyStimulus(ST | TR | RD | HD, 32'h200, 32'h100, S_RUN, 1, 0, 0);
        applyStimulus(ST,      0, 32'h104, S_RUN,  1, 0, 1);
        applyStimulus(ST | HL, 0, 32'h104, S_HALT, 1, 0, 0);
        applyStimulus(ST | RD | CL, 32'h300, 32'h104, S_HALT, 1, 0, 0);
        applyStimulus(ST | TR, 0, 32'h100, S_RUN,  1, 0, 0);
        applyStimulus(ST,      0, 32'h104, S_RUN,  1, 0, 1);

        // Fill the RAS past its depth, then unwind it
        applyStimulus(ST | RD, 32'h10, 32'h10, S_RUN, 1, 0, 0);
        applyStimulus(ST | CL, 0,      32'h14, S_RUN, 0, 0, 1);
        applyStimulus(ST | RD, 32'h30, 32'h30, S_RUN, 0, 0, 0);
        applyStimulus(ST | CL, 0,      32'h34, S_RUN, 0, 0, 1);
        applyStimulus(ST | RD, 32'h50, 32'h50, S_RUN, 0, 0, 0);
        applyStimulus(ST | CL, 0,      32'h54, S_RUN, 0, 0, 1);
        applyStimulus(ST | RD, 32'h70, 32'h70, S_RUN, 0, 0, 0);
        applyStimulus(ST | CL, 0,      32'h74, S_RUN, 0, 1, 1);
        applyStimulus(ST | RD, 32'h90, 32'h90, S_RUN, 0, 1, 0);
        applyStimulus(ST | CL, 0,      32'h94, S_RUN, 0, 1, 1);
        applyStimulus(ST | RT, 0, 32'h94, S_RUN, 0, 0, 1);
        applyStimulus(ST | RT, 0, 32'h74, S_RUN, 0, 0, 1);
        applyStimulus(ST | RT, 0, 32'h54, S_RUN, 0, 0, 1);
        applyStimulus(ST | RT, 0, 32'h34, S_RUN, 1, 0, 1);
        applyStimulus(ST | RT, 0, 32'h38, S_RUN, 1, 0, 1);

        // Simultaneous call/return, then PC wrap-around
        applyStimulus(ST | RD, 32'h10, 32'h10, S_RUN, 1, 0, 0);
        applyStimulus(ST | CL, 0,      32'h14, S_RUN, 0, 0, 1);
        applyStimulus(ST | RD, 32'h60, 32'h60, S_RUN, 0, 0, 0);
        applyStimulus(ST | CL | RT, 0, 32'h14, S_RUN, 0, 0, 1);
        applyStimulus(ST | RT, 0,      32'h64, S_RUN, 1, 0, 1);
        applyStimulus(ST | RD, 32'hFFFF_FFFC, 32'hFFFF_FFFC, S_RUN, 1, 0, 0);
        applyStimulus(ST, 0, 32'h0, S_RUN, 1, 0, 1);
        applyStimulus(ST, 0, 32'h4, S_RUN, 1, 0, 1);

        // Asynchronous reset mid-run with a live RAS entry
        applyStimulus(ST | RD, 32'h200, 32'h200, S_RUN, 1, 0, 0);
        applyStimulus(ST | CL, 0,       32'h204, S_RUN, 0, 0, 1);
        drainQueue();
        @(posedge clk);
        #3;
        zeroInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("async_pc",    step_no, bus.pc,             32'h0);
        checkOutput("async_state", step_no, 32'(bus.state),     32'(S_IDLE));
        checkOutput("async_empty", step_no, 32'(bus.ras_empty), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("held_pc",    step_no, bus.pc,         32'h0);
        checkOutput("held_state", step_no, 32'(bus.state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(ST,      0, 32'h0, S_RUN, 1, 0, 1);
        applyStimulus(ST,      0, 32'h4, S_RUN, 1, 0, 1);
        applyStimulus(ST | RT, 0, 32'h8, S_RUN, 1, 0, 1);
        drainQueue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
